// File: rtl/dct_seq_pkg.sv
`default_nettype none
// ============================================================================
// dct_seq_pkg : shared types and constants for the sequential 8x8 DCT MAC
// Rev 1.0 - initial release
// ============================================================================
package dct_seq_pkg;

    localparam int PIX_W  = 8;
    localparam int COEF_W = 8;
    localparam int OUT_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_DRAIN   = 2'd3
    } state_t;

    typedef logic signed [COEF_W-1:0] coef_t;

    // DCT-II basis scaled by 64; rows 1..7 sum to zero so flat blocks give only DC
    localparam coef_t COEF_TABLE [8][8] = '{
        '{ 8'sd23,  8'sd23,  8'sd23,  8'sd23,  8'sd23,  8'sd23,  8'sd23,  8'sd23},
        '{ 8'sd32,  8'sd27,  8'sd18,  8'sd6,  -8'sd6,  -8'sd18, -8'sd27, -8'sd32},
        '{ 8'sd30,  8'sd12, -8'sd12, -8'sd30, -8'sd30, -8'sd12,  8'sd12,  8'sd30},
        '{ 8'sd27, -8'sd6,  -8'sd32, -8'sd18,  8'sd18,  8'sd32,  8'sd6,  -8'sd27},
        '{ 8'sd23, -8'sd23, -8'sd23,  8'sd23,  8'sd23, -8'sd23, -8'sd23,  8'sd23},
        '{ 8'sd18, -8'sd32,  8'sd6,   8'sd27, -8'sd27, -8'sd6,   8'sd32, -8'sd18},
        '{ 8'sd12, -8'sd30,  8'sd30, -8'sd12, -8'sd12,  8'sd30, -8'sd30,  8'sd12},
        '{ 8'sd6,  -8'sd18,  8'sd27, -8'sd32,  8'sd32, -8'sd27,  8'sd18, -8'sd6 }
    };

    function automatic coef_t coef_at(input logic [2:0] i, input logic [2:0] k);
        return COEF_TABLE[i][k];
    endfunction

endpackage
`default_nettype wire

// File: rtl/dct_mac_unit.sv
`default_nettype none
// ============================================================================
// dct_mac_unit : one signed multiply per cycle, ACC_W accumulator, shift/round
// Optional macro DCT_MAC_SEQ_ROUND_EN adds round-half-up before the shift.
// Rev 1.0 - initial release
// ============================================================================
module dct_mac_unit
    import dct_seq_pkg::*;
#(
    parameter int COEF_FRAC = 6,
    parameter int ACC_W     = 20
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    en,
    input  logic                    first,
    input  logic [PIX_W-1:0]        pix,
    input  coef_t                   coef,
    output logic signed [OUT_W-1:0] result
);

    localparam int PROD_W = PIX_W + 1 + COEF_W;

    logic signed [PIX_W:0]    pix_s;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_next;
    logic signed [ACC_W-1:0]  acc_adj;
    logic signed [ACC_W-1:0]  acc_shift;

    assign pix_s    = {1'b0, pix};
    assign prod     = pix_s * coef;
    assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    // k=0 loads the product so no separate clear cycle is needed between elements
    assign acc_next = first ? prod_ext : acc + prod_ext;

`ifdef DCT_MAC_SEQ_ROUND_EN
    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) << (COEF_FRAC-1);
    assign acc_adj = acc_next + HALF;
`else
    assign acc_adj = acc_next;
`endif

    assign acc_shift = acc_adj >>> COEF_FRAC;
    assign result    = OUT_W'(acc_shift);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dct_mac_seq.sv
`default_nettype none
// ============================================================================
// dct_mac_seq : sequential 8x8 DCT (Y = C*X), 64-pixel buffer, 1 MAC/cycle
// Optional macro DCT_MAC_SEQ_ROUND_EN selects rounding in dct_mac_unit.
// Rev 1.0 - initial release
// ============================================================================
module dct_mac_seq
    import dct_seq_pkg::*;
#(
    parameter int COEF_FRAC = 6,
    parameter int ACC_W     = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [15:0] out_data,
    input  logic        out_ready,
    input  logic        abort,
    output logic        busy,
    output logic        done
);

    state_t state, state_next;

    logic [PIX_W-1:0] pix_buf [64];
    logic [5:0]       wr_idx;
    logic [2:0]       gen_i, gen_j, gen_k;
    logic             gen_done;
    logic             op_valid, op_first, op_last, op_final;
    logic [PIX_W-1:0] op_pix;
    coef_t            op_coef;
    logic signed [OUT_W-1:0] mac_result;
    logic             in_fire, out_fire, stall, mac_en, mac_last_fire, issue;

    assign in_fire       = in_valid & in_ready;
    assign out_fire      = out_valid & out_ready;
    // Only a finished result blocked by a full output register stops the pipe
    assign stall         = op_valid & op_last & out_valid & ~out_ready;
    assign mac_en        = op_valid & ~stall & ~abort;
    assign mac_last_fire = mac_en & op_last;
    assign issue         = (state == ST_COMPUTE) & ~gen_done & ~stall & ~abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    if (in_fire) state_next = ST_LOAD;
                ST_LOAD:    if (in_fire && wr_idx == 6'd63) state_next = ST_COMPUTE;
                ST_COMPUTE: if (mac_last_fire && op_final) state_next = ST_DRAIN;
                ST_DRAIN:   if (out_fire) state_next = ST_IDLE;
                default:    state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy     = (state != ST_IDLE);
        in_ready = (state == ST_IDLE) || (state == ST_LOAD);
    end

    always_ff @(posedge clk) begin
        if (in_fire && !abort) pix_buf[wr_idx] <= in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx    <= '0;
            {gen_i, gen_j, gen_k} <= '0;
            gen_done  <= 1'b0;
            op_valid  <= 1'b0;
            op_first  <= 1'b0;
            op_last   <= 1'b0;
            op_final  <= 1'b0;
            op_pix    <= '0;
            op_coef   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            done      <= 1'b0;
        end else if (abort) begin
            wr_idx    <= '0;
            {gen_i, gen_j, gen_k} <= '0;
            gen_done  <= 1'b0;
            op_valid  <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= (state == ST_DRAIN) && out_fire;
            if (in_fire) wr_idx <= wr_idx + 6'd1;

            // Operand fetch: X[k][j] and C[i][k], i/j/k counted as one 9-bit index
            if (issue) begin
                op_valid <= 1'b1;
                op_pix   <= pix_buf[{gen_k, gen_j}];
                op_coef  <= coef_at(gen_i, gen_k);
                op_first <= (gen_k == 3'd0);
                op_last  <= (gen_k == 3'd7);
                op_final <= &{gen_i, gen_j, gen_k};
                {gen_i, gen_j, gen_k} <= {gen_i, gen_j, gen_k} + 9'd1;
                if (&{gen_i, gen_j, gen_k}) gen_done <= 1'b1;
            end else if (!stall) begin
                op_valid <= 1'b0;
            end

            if (mac_last_fire) begin
                out_valid <= 1'b1;
                out_data  <= mac_result;
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end

            if (state == ST_DRAIN && out_fire) begin
                gen_done <= 1'b0;
                wr_idx   <= '0;
            end
        end
    end

    dct_mac_unit #(
        .COEF_FRAC (COEF_FRAC),
        .ACC_W     (ACC_W)
    ) u_mac (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (abort),
        .en     (mac_en),
        .first  (op_first),
        .pix    (op_pix),
        .coef   (op_coef),
        .result (mac_result)
    );

endmodule
`default_nettype wire

// File: tb/tb_dct_mac_seq.sv
`default_nettype none
// ============================================================================
// tb_dct_mac_seq : scoreboard bench for dct_mac_seq (flat, stalled, random,
// abort and mid-load reset blocks). Honours DCT_MAC_SEQ_ROUND_EN.
// Rev 1.0 - initial release
// ============================================================================
module tb_dct_mac_seq;
    import dct_seq_pkg::*;

    localparam int COEF_FRAC = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready = 1'b1;
    logic        abort = 1'b0;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc_cyc  = 0;
    int pop_cnt  = 0;
    int done_cnt = 0;
    int last_hs  = 0;
    bit chk_spacing = 1'b0;

    logic [15:0] expq [$];
    logic [7:0]  blk [64];

`ifdef DCT_MAC_SEQ_ROUND_EN
    localparam int DC100 = 288;
`else
    localparam int DC100 = 287;
`endif
    localparam int DC255 = 733;

    dct_mac_seq #(.COEF_FRAC(COEF_FRAC), .ACC_W(20)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .abort     (abort),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     tag, got, got, exp, exp, cyc);
        end
    endtask

    // Flat block: only Y[0][*] is non-zero
    task automatic push_flat(input int dc);
        for (int e = 0; e < 64; e++) expq.push_back((e < 8) ? 16'(dc) : 16'd0);
    endtask

    task automatic push_model();
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                int s = 0;
                for (int k = 0; k < 8; k++) s += int'(COEF_TABLE[i][k]) * int'(blk[k*8+j]);
`ifdef DCT_MAC_SEQ_ROUND_EN
                s += 1 << (COEF_FRAC-1);
`endif
                s = s >>> COEF_FRAC;
                expq.push_back(s[15:0]);
            end
        end
    endtask

    task automatic send_pixels(input int n);
        for (int p = 0; p < n; p++) begin
            int t = 0;
            while (!in_ready && t < 2000) begin
                @(posedge clk); #1; t++;
            end
            if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 1);
            in_valid = 1'b1;
            in_data  = blk[p];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        acc_cyc  = cyc;
    endtask

    task automatic wait_done(input int d0);
        int t = 0;
        while (done_cnt == d0 && t < 3000) begin
            @(posedge clk); #1; t++;
        end
        chk("done_seen", 32'(done_cnt), 32'(d0 + 1));
        repeat (4) @(posedge clk);
        #1;
        chk("done_once", 32'(done_cnt), 32'(d0 + 1));
        chk("queue_drained", 32'(expq.size()), 0);
        chk("idle_after", 32'(busy), 0);
    endtask

    // Output monitor: scoreboard pop, hold stability, latency, spacing, done timing
    initial begin
        logic [15:0] held = '0;
        bit hold_pending  = 1'b0;
        bit exp_done_next = 1'b0;
        bit prev_ov       = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                expq.delete();
                pop_cnt = 0; hold_pending = 0; exp_done_next = 0; prev_ov = 0;
            end else begin
                if (exp_done_next) chk("done_after_last", 32'(done), 1);
                if (done) begin
                    done_cnt++;
                    chk("busy_low_with_done", 32'(busy), 0);
                end
                if (hold_pending) begin
                    chk("hold_valid", 32'(out_valid), 1);
                    chk("hold_data", 32'(out_data), 32'(held));
                end
                if (!prev_ov && out_valid && pop_cnt == 0)
                    chk("latency", 32'(cyc - acc_cyc), 9);
                exp_done_next = 1'b0;
                if (abort) begin
                    expq.delete();
                    pop_cnt = 0; hold_pending = 0;
                end else begin
                    hold_pending = out_valid && !out_ready;
                    held = out_data;
                    if (out_valid && out_ready) begin
                        if (expq.size() == 0) chk("extra_output", 0, 1);
                        else chk("out_data", 32'(out_data), 32'(expq.pop_front()));
                        if (chk_spacing && pop_cnt > 0) chk("spacing", 32'(cyc - last_hs), 8);
                        last_hs = cyc;
                        if (pop_cnt == 63) begin
                            exp_done_next = 1'b1;
                            pop_cnt = 0;
                        end else begin
                            pop_cnt++;
                        end
                    end
                end
                prev_ov = out_valid;
            end
        end
    end

    initial begin
        int d0;
        #3;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_in_ready", 32'(in_ready), 1);

        // Flat 100 block, out_ready held high, stray in_valid during COMPUTE
        for (int p = 0; p < 64; p++) blk[p] = 8'd100;
        push_flat(DC100);
        chk_spacing = 1'b1;
        d0 = done_cnt;
        send_pixels(64);
        in_valid = 1'b1; in_data = 8'hFF;
        repeat (5) begin
            @(posedge clk); #1;
            chk("in_ready_compute", 32'(in_ready), 0);
            chk("busy_compute", 32'(busy), 1);
        end
        in_valid = 1'b0;
        wait_done(d0);
        chk_spacing = 1'b0;

        // Same block, out_ready dropped for 30 cycles at element 5
        push_flat(DC100);
        d0 = done_cnt;
        fork
            send_pixels(64);
            begin
                for (int t = 0; t < 2000 && pop_cnt != 5; t++) begin
                    @(posedge clk); #1;
                end
                out_ready = 1'b0;
                repeat (30) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_done(d0);

        // Random pixels with random back-pressure, checked against the math model
        for (int p = 0; p < 64; p++) blk[p] = 8'($urandom_range(0, 255));
        push_model();
        d0 = done_cnt;
        fork
            send_pixels(64);
            begin
                for (int c = 0; c < 1500 && done_cnt == d0; c++) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        wait_done(d0);

        // Abort at element 20, then a flat 255 block
        for (int p = 0; p < 64; p++) blk[p] = 8'd100;
        push_flat(DC100);
        d0 = done_cnt;
        send_pixels(64);
        for (int t = 0; t < 2000 && pop_cnt != 20; t++) begin
            @(posedge clk); #1;
        end
        chk("reached_elem20", 32'(pop_cnt), 20);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_out_valid", 32'(out_valid), 0);
        repeat (20) @(posedge clk);
        #1;
        chk("abort_no_done", 32'(done_cnt), 32'(d0));
        chk("abort_no_output", 32'(out_valid), 0);
        for (int p = 0; p < 64; p++) blk[p] = 8'd255;
        push_flat(DC255);
        d0 = done_cnt;
        send_pixels(64);
        wait_done(d0);

        // Reset during LOAD at pixel 30, then a full random block
        for (int p = 0; p < 64; p++) blk[p] = 8'($urandom_range(0, 255));
        send_pixels(30);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_out_data", 32'(out_data), 0);
        chk("midrst_done", 32'(done), 0);
        chk("midrst_in_ready", 32'(in_ready), 1);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("postrst_no_output", 32'(out_valid), 0);
        chk("postrst_idle", 32'(busy), 0);
        push_model();
        d0 = done_cnt;
        send_pixels(64);
        wait_done(d0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
